temp_sampler: RTL and testbench

Upstream front-end for the smart-home aircon controller. It periodically reads an 8-bit serial temperature sensor over a 3-wire SPI-style link and clamps each reading to the 5-bit range the aircon stage consumes. It smooths the last four readings with a moving average and presents the result as a held 5-bit `temperature` bus plus a one-cycle update strobe. The aircon stage's hysteresis logic reads `temperature` directly.

---
 rtl/smart_home_pkg.sv | 19 +
 rtl/sensor_spi_rx.sv | 64 ++++++
 rtl/temp_sampler.sv | 103 ++++++++++
 tb/tb_temp_sampler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/smart_home_pkg.sv
// Shared widths, limits and FSM encoding for the temperature front-end.
`timescale 1ns/1ps
package smart_home_pkg;
   localparam int TEMP_W     = 5;
   localparam int RAW_W      = 8;
   localparam int HIST_DEPTH = 4;
   localparam int TEMP_MAX   = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      AVG  = 2'd2,
      OUT  = 2'd3
   } sampler_state_t;

   function automatic logic [TEMP_W-1:0] clamp_temp(input logic [RAW_W-1:0] raw);
      return (raw > RAW_W'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : raw[TEMP_W-1:0];
   endfunction
endpackage

// File: rtl/sensor_spi_rx.sv
// Reads one 8-bit frame from the serial sensor: cs_n/sck generation, MSB-first capture.
`timescale 1ns/1ps
module sensor_spi_rx
   import smart_home_pkg::*;
#(
   parameter int SCK_DIV = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_sdo,
   output logic             o_cs_n,
   output logic             o_sck,
   output logic             o_done,
   output logic [RAW_W-1:0] o_raw
);
   localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

   logic             r_busy;
   logic [DIV_W-1:0] r_div;
   logic [3:0]       r_tgl_cnt;
   logic             r_sck;
   logic             r_cs_n;
   logic [RAW_W-1:0] r_shift;
   logic             w_tc;

   assign w_tc   = r_busy && (r_div == DIV_W'(SCK_DIV - 1));
   // Done coincides with the 16th toggle, which also returns sck low.
   assign o_done = w_tc && (r_tgl_cnt == 4'd15);
   assign o_cs_n = r_cs_n;
   assign o_sck  = r_sck;
   assign o_raw  = r_shift;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy    <= 1'b0;
         r_div     <= '0;
         r_tgl_cnt <= '0;
         r_sck     <= 1'b0;
         r_cs_n    <= 1'b1;
         r_shift   <= '0;
      end else if (i_start && !r_busy) begin
         r_busy    <= 1'b1;
         r_cs_n    <= 1'b0;
         r_div     <= '0;
         r_tgl_cnt <= '0;
         r_sck     <= 1'b0;
      end else if (r_busy) begin
         if (w_tc) begin
            r_div     <= '0;
            r_sck     <= ~r_sck;
            r_tgl_cnt <= r_tgl_cnt + 4'd1;
            if (!r_sck)
               r_shift <= {r_shift[RAW_W-2:0], i_sdo};
            if (r_tgl_cnt == 4'd15) begin
               r_busy <= 1'b0;
               r_cs_n <= 1'b1;
            end
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end
endmodule

// File: rtl/temp_sampler.sv
// Periodic sensor read, clamp to 5 bits, 4-tap moving average, held output with strobe.
`timescale 1ns/1ps
module temp_sampler
   import smart_home_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 50,
   parameter int SCK_DIV       = 2,
   parameter int RESET_TEMP    = 20
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sdo,
   output logic              o_cs_n,
   output logic              o_sck,
   output logic [TEMP_W-1:0] o_temperature,
   output logic              o_temp_valid,
   output logic              o_sat
);
   localparam int PW    = $clog2(SAMPLE_PERIOD);
   localparam int SUM_W = TEMP_W + 2;

   sampler_state_t                         r_state, w_next;
   logic [PW-1:0]                          r_per;
   logic                                   r_wrap;
   logic [HIST_DEPTH-1:0][TEMP_W-1:0]      r_hist;
   logic [SUM_W-1:0]                       r_sum;
   logic [TEMP_W-1:0]                      r_temp;
   logic                                   r_valid;
   logic                                   r_sat;
   logic                                   w_start;
   logic                                   w_done;
   logic [RAW_W-1:0]                       w_raw;
   logic [TEMP_W-1:0]                      w_clamped;
   logic [SUM_W-1:0]                       w_sum;

   // Wrap is registered so the first cs_n fall lands exactly SAMPLE_PERIOD edges after release.
   assign w_start = (r_state == IDLE) && r_wrap;

   sensor_spi_rx #(.SCK_DIV(SCK_DIV)) u_rx (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (w_start),
      .i_sdo   (i_sdo),
      .o_cs_n  (o_cs_n),
      .o_sck   (o_sck),
      .o_done  (w_done),
      .o_raw   (w_raw)
   );

   assign w_clamped = clamp_temp(w_raw);

   always_comb begin
      w_sum = SUM_W'(w_clamped);
      for (int i = 0; i < HIST_DEPTH - 1; i++)
         w_sum = w_sum + SUM_W'(r_hist[i]);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = CONV;
         CONV:    if (w_done)  w_next = AVG;
         AVG:     w_next = OUT;
         OUT:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_per   <= '0;
         r_wrap  <= 1'b0;
         r_hist  <= {HIST_DEPTH{TEMP_W'(RESET_TEMP)}};
         r_sum   <= '0;
         r_temp  <= TEMP_W'(RESET_TEMP);
         r_valid <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_per   <= (r_per == PW'(SAMPLE_PERIOD - 1)) ? '0 : r_per + PW'(1);
         r_wrap  <= (r_per == PW'(SAMPLE_PERIOD - 1));
         r_valid <= 1'b0;
         r_sat   <= 1'b0;
         if (r_state == AVG) begin
            r_hist <= {r_hist[HIST_DEPTH-2:0], w_clamped};
            r_sum  <= w_sum;
         end
         if (r_state == OUT) begin
            r_temp  <= r_sum[SUM_W-1:2];
            r_valid <= 1'b1;
            r_sat   <= (w_raw > RAW_W'(TEMP_MAX));
         end
      end
   end

   assign o_temperature = r_temp;
   assign o_temp_valid  = r_valid;
   assign o_sat         = r_sat;
endmodule

// File: tb/tb_temp_sampler.sv
// Directed bench for temp_sampler with a behavioural MSB-first sensor.
`timescale 1ns/1ps
module tb_temp_sampler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sdo = 1'b0;
   logic       o_cs_n, o_sck, o_temp_valid, o_sat;
   logic [4:0] o_temperature;

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = -1;
   int         last_fall = -1;
   logic [4:0] prev_temp = 5'd20;

   logic [7:0] sens_byte = 8'd24;
   int         idx = 7;
   logic       prev_cs = 1'b1;
   logic       prev_sck = 1'b0;

   temp_sampler #(.SAMPLE_PERIOD(50), .SCK_DIV(2), .RESET_TEMP(20)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sdo         (sdo),
      .o_cs_n        (o_cs_n),
      .o_sck         (o_sck),
      .o_temperature (o_temperature),
      .o_temp_valid  (o_temp_valid),
      .o_sat         (o_sat)
   );

   always #5 clk = ~clk;

   // Sensor: present MSB on cs_n fall, advance one bit after each sck fall.
   always @(negedge clk) begin
      if (prev_cs && !o_cs_n) idx = 7;
      else if (prev_sck && !o_sck && idx > 0) idx = idx - 1;
      sdo      = sens_byte[idx];
      prev_cs  = o_cs_n;
      prev_sck = o_sck;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic r;
      r = rst;
      @(negedge clk);
      cyc++;
      if (!r && (o_temperature !== prev_temp))
         check("temp_hold", int'(o_temp_valid), 1);
      prev_temp = o_temperature;
   endtask

   task automatic conv(input logic [7:0] b, input int exp_t, input int exp_sat);
      int   f, rises, first, prev_r, gap_bad, vcyc;
      logic ps;
      sens_byte = b;
      f = -1;
      for (int i = 0; i < 200 && f < 0; i++) begin
         ps = o_cs_n;
         tick();
         if (ps && !o_cs_n) f = cyc;
      end
      check("cs_n_fall_seen", int'(f >= 0), 1);
      check("period", f - last_fall, 50);
      last_fall = f;
      rises = 0; first = -1; prev_r = -1; gap_bad = 0; vcyc = -1;
      for (int i = 0; i < 100 && vcyc < 0; i++) begin
         ps = o_sck;
         tick();
         if (!ps && o_sck) begin
            rises++;
            if (first < 0) first = cyc;
            else if (cyc - prev_r != 4) gap_bad++;
            prev_r = cyc;
         end
         if (o_temp_valid) vcyc = cyc;
      end
      check("first_rise", first - f, 2);
      check("rise_count", rises, 8);
      check("rise_gap_errs", gap_bad, 0);
      check("valid_latency", vcyc - f, 34);
      check("temperature", int'(o_temperature), exp_t);
      check("sat", int'(o_sat), exp_sat);
      check("cs_n_at_valid", int'(o_cs_n), 1);
      tick();
      check("valid_pulse", int'(o_temp_valid), 0);
      check("sat_pulse", int'(o_sat), 0);
   endtask

   initial begin
      int   f, rises, nv;
      logic ps;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cs_n", int'(o_cs_n), 1);
      check("rst_sck", int'(o_sck), 0);
      check("rst_temp", int'(o_temperature), 20);
      check("rst_valid", int'(o_temp_valid), 0);
      check("rst_sat", int'(o_sat), 0);
      rst = 1'b0;
      cyc = -1;
      last_fall = 0;
      prev_temp = o_temperature;

      // Ramp from reset history 20 toward 24.
      conv(8'd24, 21, 0);
      conv(8'd24, 22, 0);
      conv(8'd24, 23, 0);
      conv(8'd24, 24, 0);
      // Out-of-range reading clamps to 31, then flushes back out.
      conv(8'd200, 25, 1);
      conv(8'd24, 25, 0);
      conv(8'd24, 25, 0);
      conv(8'd24, 25, 0);
      conv(8'd24, 24, 0);
      // Average down.
      conv(8'd16, 22, 0);
      conv(8'd16, 20, 0);
      conv(8'd16, 18, 0);
      conv(8'd16, 16, 0);

      // Reset on the 4th sck rise of a conversion.
      sens_byte = 8'd16;
      f = -1;
      for (int i = 0; i < 200 && f < 0; i++) begin
         ps = o_cs_n;
         tick();
         if (ps && !o_cs_n) f = cyc;
      end
      check("mid_fall_seen", int'(f >= 0), 1);
      rises = 0;
      for (int i = 0; i < 100 && rises < 4; i++) begin
         ps = o_sck;
         tick();
         if (!ps && o_sck) rises++;
      end
      check("mid_rises", rises, 4);
      rst = 1'b1;
      tick();
      check("mid_cs_n", int'(o_cs_n), 1);
      check("mid_sck", int'(o_sck), 0);
      check("mid_temp", int'(o_temperature), 20);
      rst = 1'b0;
      cyc = -1;
      f = -1; nv = 0;
      for (int i = 0; i < 200 && f < 0; i++) begin
         ps = o_cs_n;
         tick();
         if (o_temp_valid) nv++;
         if (ps && !o_cs_n) f = cyc;
      end
      check("mid_no_valid", nv, 0);
      check("mid_temp_after", int'(o_temperature), 20);
      check("mid_refall", f, 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
